// File: rtl/rr_arbiter16.sv
// rr_arbiter16: fair 16-way round-robin arbiter with a bounded grant tenure.
// Ports: clk, rst (async, active-high), req[15:0] in; grant[15:0], grant_id[3:0], grant_valid out.
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic [3:0]  grant_id,
  output logic        grant_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  state_t      state_q, state_d;
  logic [15:0] grant_q, grant_d;
  logic [3:0]  id_q, id_d;
  logic [3:0]  last_q, last_d;
  logic [7:0]  hold_q, hold_d;

  logic [15:0] others;
  logic        own_req;
  logic [15:0] src;
  logic        win_found;
  logic [3:0]  win_id;
  logic [3:0]  idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= 4'd15;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // While busy the owner's own bit is masked out, so a handoff
  // never re-selects the current owner.
  assign others  = req & ~grant_q;
  assign own_req = |(req & grant_q);
  assign src     = (state_q == IDLE) ? req : others;

  // Search starts one past the previous winner and wraps; the
  // 16th step lands back on last_q itself.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_q;
    idx       = last_q;
    for (int k = 1; k <= 16; k++) begin
      idx = last_q + 4'(k);
      if (!win_found && src[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          grant_d = 16'h1 << win_id;
          id_d    = win_id;
          last_d  = win_id;
          hold_d  = 8'd1;
        end
      end
      BUSY: begin
        if (!own_req) begin
          if (win_found) begin
            grant_d = 16'h1 << win_id;
            id_d    = win_id;
            last_d  = win_id;
            hold_d  = 8'd1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (hold_q == MaxHold) begin
          hold_d = 8'd1;
          if (win_found) begin
            grant_d = 16'h1 << win_id;
            id_d    = win_id;
            last_d  = win_id;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    grant       = grant_q;
    grant_id    = id_q;
    grant_valid = (state_q == BUSY);
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed checks of rr_arbiter16 with MAX_HOLD=8.
// Drives req/rst, checks grant/grant_id/grant_valid one time unit after each edge.
module tb_rr_arbiter16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;

  int checks;
  int failures;

  rr_arbiter16 #(.MAX_HOLD(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] g,
                         input logic [3:0] id, input logic v);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_id"}, 32'(grant_id), 32'(id));
    chk({tag, "_valid"}, 32'(grant_valid), 32'(v));
  endtask

  // Mid-cycle reset pulse: returns last_id to 15.
  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] base;
    logic [3:0]  exp_seq [5];
    int          waits [16];
    logic [15:0] rq;
    logic        ok;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;

    repeat (2) tick();
    chk_out("reset", 16'h0000, 4'd0, 1'b0);
    rst = 1'b0;

    // Single request, latency one edge, release to idle.
    req = 16'h0010;
    tick();
    chk_out("single", 16'h0010, 4'd4, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk_out("single_hold", 16'h0010, 4'd4, 1'b1);
    req = 16'h0000;
    tick();
    chk_out("release_idle", 16'h0000, 4'd4, 1'b0);

    // Round-robin with one-cycle tenure via release.
    rst_pulse();
    base = 16'h8421;
    exp_seq[0] = 4'd0;
    exp_seq[1] = 4'd5;
    exp_seq[2] = 4'd10;
    exp_seq[3] = 4'd15;
    exp_seq[4] = 4'd0;
    req = base;
    tick();
    chk_out("rr0", 16'h0001, 4'd0, 1'b1);
    for (int i = 1; i < 5; i++) begin
      req = base & ~(16'h1 << exp_seq[i-1]);
      tick();
      chk_out("rr", 16'h1 << exp_seq[i], exp_seq[i], 1'b1);
    end

    // Timeout alternation, then sole requester keeps grant.
    rst_pulse();
    req = 16'h0003;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("timeout_id", 32'(grant_id), 32'((i / 8) % 2));
    end
    req = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("solo_grant", 32'(grant), 32'h1);
    end

    // Wrap-around from requester 15 back to 0.
    rst_pulse();
    req = 16'h8000;
    tick();
    chk_out("wrap15", 16'h8000, 4'd15, 1'b1);
    req = 16'h0000;
    tick();
    chk("wrap_idle", 32'(grant_valid), 32'h0);
    req = 16'h8001;
    tick();
    chk_out("wrap0", 16'h0001, 4'd0, 1'b1);
    req = 16'h8000;
    tick();
    chk_out("wrap15b", 16'h8000, 4'd15, 1'b1);

    // Asynchronous reset mid-grant.
    rst_pulse();
    req = 16'h0200;
    tick();
    chk_out("own9", 16'h0200, 4'd9, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 16'h0000, 4'd0, 1'b0);
    req = 16'hFFFF;
    tick();
    chk_out("rst_held", 16'h0000, 4'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("all_first", 16'h0001, 4'd0, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      repeat (8) tick();
      chk("all_cycle", 32'(grant_id), 32'(j % 16));
    end

    // Random traffic: one-hot, grant/id agreement, bounded wait.
    for (int i = 0; i < 16; i++) waits[i] = 0;
    for (int c = 0; c < 600; c++) begin
      rq  = 16'($urandom);
      req = rq;
      tick();
      ok = (grant == 16'h0) ? !grant_valid
                            : (grant_valid && grant == (16'h1 << grant_id));
      chk("inv_onehot", 32'(ok), 32'h1);
      ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (rq[i] && !grant[i]) waits[i]++;
        else waits[i] = 0;
        if (waits[i] > 15 * 8 + 1) ok = 1'b0;
      end
      chk("inv_wait", 32'(ok), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
